peripheral_msi_arbiter_ahb3: RTL and testbench

Parametrised per-slave-port arbiter for the AHB3 multi-master interconnect. It replaces fixed arbitration inside each slave port with a registered grant. Arbitration is by priority level, with round-robin among masters at the same level. The grant is held through bursts and HMASTLOCK sequences, and optional aging counters prevent starvation. One instance sits in every slave port. It receives the per-master request and control vectors and drives the one-hot `granted_master` returned to the master ports.

---
 rtl/peripheral_msi_pkg_ahb3.sv | 18 +
 rtl/peripheral_msi_rr_pick.sv | 38 +++
 rtl/peripheral_msi_arbiter_ahb3.sv | 191 +++++++++++++++++++
 tb/tb_peripheral_msi_arbiter_ahb3.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_msi_pkg_ahb3.sv
// Shared definitions for the AHB3 slave-port arbiter: HTRANS encodings,
// arbiter state enum and the default aging limit.
package peripheral_msi_pkg_ahb3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int unsigned MSI_AGE_LIMIT_DEFAULT = 64;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY   = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

endpackage

// File: rtl/peripheral_msi_rr_pick.sv
// Combinational round-robin pick.
// Searches req starting at the index after last, wrapping around; returns
// the first hit as one-hot plus binary index, and whether any bit was set.
//   req        : candidate mask
//   last       : previous winner index (search starts at last+1)
//   pick_oh_c  : one-hot winner
//   pick_idx_c : binary winner index
//   any_c      : at least one candidate present
module peripheral_msi_rr_pick #(
  parameter int unsigned N  = 5,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick_oh_c,
  output logic [IW-1:0] pick_idx_c,
  output logic          any_c
);

  // Walk N positions after last; the last position visited is last itself,
  // so the previous winner only wins again when nobody else is a candidate.
  always_comb begin
    logic [IW-1:0] pos;
    pick_oh_c  = '0;
    pick_idx_c = '0;
    any_c      = 1'b0;
    pos        = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = IW'((32'(last) + k) % N);
      if (!any_c && req[pos]) begin
        any_c          = 1'b1;
        pick_oh_c[pos] = 1'b1;
        pick_idx_c     = pos;
      end
    end
  end

endmodule

// File: rtl/peripheral_msi_arbiter_ahb3.sv
// Per-slave-port AHB3 arbiter with registered grant.
// Priority arbitration with round-robin among equal keys; grant is held
// through bursts (until can_switch or request drop) and HMASTLOCK sequences.
// Optional starvation aging is enabled by defining MSI_ARB_AGING_EN.
//   HCLK, HRESETn   : clock, async active-low reset
//   mst_priority    : per-master priority, higher wins
//   mst_req         : per-master request to this slave
//   mst_HTRANS      : per-master transfer type
//   mst_HMASTLOCK   : per-master lock
//   can_switch      : per-master burst-boundary indication
//   slv_HREADY      : slave accepted address phase; all arbitration advances on it
//   granted_master  : one-hot address-phase grant
//   granted_idx     : binary index of granted_master
//   grant_valid     : owner is an active requester
//   data_master     : one-hot data-phase owner
//   starved         : per-master aged flags
module peripheral_msi_arbiter_ahb3
  import peripheral_msi_pkg_ahb3::*;
#(
  parameter int unsigned MASTERS   = 5,
  parameter int unsigned PRIO_W    = 3,
  parameter int unsigned AGE_W     = 8,
  parameter int unsigned AGE_LIMIT = MSI_AGE_LIMIT_DEFAULT,
  localparam int unsigned IDX_W    = (MASTERS > 1) ? $clog2(MASTERS) : 1,
  localparam int unsigned KEY_W    = PRIO_W + 1
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [MASTERS*PRIO_W-1:0] mst_priority,
  input  logic [MASTERS-1:0]        mst_req,
  input  logic [MASTERS*2-1:0]      mst_HTRANS,
  input  logic [MASTERS-1:0]        mst_HMASTLOCK,
  input  logic [MASTERS-1:0]        can_switch,
  input  logic                      slv_HREADY,
  output logic [MASTERS-1:0]        granted_master,
  output logic [IDX_W-1:0]          granted_idx,
  output logic                      grant_valid,
  output logic [MASTERS-1:0]        data_master,
  output logic [MASTERS-1:0]        starved
);

  arb_state_e         state_q, state_d;
  logic [MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               valid_q, valid_d;
  logic [MASTERS-1:0] data_q;

  logic [1:0]         htrans [MASTERS];
  logic [KEY_W-1:0]   key    [MASTERS];
  logic [MASTERS-1:0] aged;
  logic [KEY_W-1:0]   max_key;
  logic [MASTERS-1:0] top_mask;

  logic [MASTERS-1:0] pick_oh_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic               pick_any_c;

  // Unpack per-master fields and form the arbitration key {aged, priority}.
  always_comb begin
    for (int i = 0; i < MASTERS; i++) begin
      htrans[i] = mst_HTRANS[2*i +: 2];
      key[i]    = {aged[i], mst_priority[PRIO_W*i +: PRIO_W]};
    end
  end

  // Highest key among requesters, and the set of requesters holding it.
  always_comb begin
    max_key  = '0;
    top_mask = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (mst_req[i] && (key[i] > max_key)) max_key = key[i];
    end
    for (int i = 0; i < MASTERS; i++) begin
      top_mask[i] = mst_req[i] && (key[i] == max_key);
    end
  end

  peripheral_msi_rr_pick #(
    .N  (MASTERS),
    .IW (IDX_W)
  ) u_rr_pick (
    .req        (top_mask),
    .last       (last_q),
    .pick_oh_c  (pick_oh_c),
    .pick_idx_c (pick_idx_c),
    .any_c      (pick_any_c)
  );

  // Next-state logic: everything holds unless slv_HREADY is high.
  always_comb begin
    logic rearb;
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    rearb   = 1'b0;
    if (slv_HREADY) begin
      unique case (state_q)
        ARB_IDLE: rearb = 1'b1;
        ARB_BUSY: begin
          // Lock entry takes precedence over a burst-boundary switch.
          if (mst_HMASTLOCK[idx_q] && (htrans[idx_q] == HTRANS_NONSEQ)) begin
            state_d = ARB_LOCKED;
          end else if (can_switch[idx_q] || !mst_req[idx_q]) begin
            rearb = 1'b1;
          end
        end
        ARB_LOCKED: begin
          if (!mst_HMASTLOCK[idx_q] && (htrans[idx_q] == HTRANS_IDLE)) begin
            state_d = ARB_BUSY;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
      if (rearb) begin
        if (pick_any_c) begin
          grant_d = pick_oh_c;
          idx_d   = pick_idx_c;
          last_d  = pick_idx_c;
          valid_d = 1'b1;
          state_d = ARB_BUSY;
        end else begin
          // Park on the current owner.
          valid_d = 1'b0;
          state_d = ARB_IDLE;
        end
      end
    end
  end

  // Arbiter state registers and data-phase pipeline.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ARB_IDLE;
      grant_q <= MASTERS'(1);
      idx_q   <= '0;
      last_q  <= IDX_W'(MASTERS - 1);
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      if (slv_HREADY) data_q <= grant_q & {MASTERS{valid_q}};
    end
  end

`ifdef MSI_ARB_AGING_EN
  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_LIMIT);

  logic [AGE_W-1:0]   age_q [MASTERS];
  logic [MASTERS-1:0] starved_q;

  // Waiting-time counters; run every cycle independent of slv_HREADY.
  // starved_q mirrors "next counter value == AGE_LIMIT".
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < MASTERS; i++) age_q[i] <= '0;
      starved_q <= '0;
    end else begin
      for (int i = 0; i < MASTERS; i++) begin
        if (!mst_req[i] || grant_d[i]) begin
          age_q[i]     <= '0;
          starved_q[i] <= 1'b0;
        end else begin
          if (age_q[i] != AGE_SAT) age_q[i] <= age_q[i] + AGE_W'(1);
          starved_q[i] <= (age_q[i] >= (AGE_SAT - AGE_W'(1)));
        end
      end
    end
  end

  assign aged    = starved_q;
  assign starved = starved_q;
`else
  logic unused_age_cfg;
  assign unused_age_cfg = ^(AGE_W'(AGE_LIMIT));
  assign aged    = '0;
  assign starved = '0;
`endif

  assign granted_master = grant_q;
  assign granted_idx    = idx_q;
  assign grant_valid    = valid_q;
  assign data_master    = data_q;

endmodule

// File: tb/tb_peripheral_msi_arbiter_ahb3.sv
// Self-checking bench for peripheral_msi_arbiter_ahb3 (MASTERS=5).
// Directed scenarios push expected outputs into a scoreboard queue as each
// cycle's stimulus is driven; entries are popped after the clock edge.
module tb_peripheral_msi_arbiter_ahb3;
  import peripheral_msi_pkg_ahb3::*;

  localparam int unsigned M  = 5;
  localparam int unsigned PW = 3;
`ifdef MSI_ARB_AGING_EN
  localparam int unsigned TB_AGE_LIMIT = 4;
`else
  localparam int unsigned TB_AGE_LIMIT = 64;
`endif

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [M*PW-1:0] mst_priority;
  logic [M-1:0]    mst_req;
  logic [M*2-1:0]  mst_HTRANS;
  logic [M-1:0]    mst_HMASTLOCK;
  logic [M-1:0]    can_switch;
  logic            slv_HREADY;
  logic [M-1:0]    granted_master;
  logic [2:0]      granted_idx;
  logic            grant_valid;
  logic [M-1:0]    data_master;
  logic [M-1:0]    starved;

  typedef struct packed {
    logic [M-1:0] grant;
    logic [2:0]   idx;
    logic         valid;
    logic [M-1:0] data;
    logic [M-1:0] stv;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step     = 0;
  bit   check_starved;

  peripheral_msi_arbiter_ahb3 #(
    .MASTERS   (M),
    .PRIO_W    (PW),
    .AGE_W     (8),
    .AGE_LIMIT (TB_AGE_LIMIT)
  ) dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .mst_priority   (mst_priority),
    .mst_req        (mst_req),
    .mst_HTRANS     (mst_HTRANS),
    .mst_HMASTLOCK  (mst_HMASTLOCK),
    .can_switch     (can_switch),
    .slv_HREADY     (slv_HREADY),
    .granted_master (granted_master),
    .granted_idx    (granted_idx),
    .grant_valid    (grant_valid),
    .data_master    (data_master),
    .starved        (starved)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] oh2idx(input logic [M-1:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < M; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  task automatic set_prio(input int i, input int p);
    mst_priority[i*PW +: PW] = PW'(p);
  endtask

  task automatic set_htrans(input int i, input logic [1:0] t);
    mst_HTRANS[i*2 +: 2] = t;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_grant"}, 32'(granted_master), 32'd1);
    check({tag, "_idx"},   32'(granted_idx),    32'd0);
    check({tag, "_valid"}, 32'(grant_valid),    32'd0);
    check({tag, "_data"},  32'(data_master),    32'd0);
    check({tag, "_stv"},   32'(starved),        32'd0);
  endtask

  // One clock: queue the expectation for this edge, then compare after it.
  task automatic cyc(input logic [M-1:0] g, input logic v, input logic [M-1:0] d,
                     input logic [M-1:0] s);
    exp_t e;
    sb_q.push_back('{grant: g, idx: oh2idx(g), valid: v, data: d, stv: s});
    @(posedge HCLK);
    #1;
    step++;
    e = sb_q.pop_front();
    check($sformatf("grant@%0d", step), 32'(granted_master), 32'(e.grant));
    check($sformatf("idx@%0d",   step), 32'(granted_idx),    32'(e.idx));
    check($sformatf("valid@%0d", step), 32'(grant_valid),    32'(e.valid));
    check($sformatf("data@%0d",  step), 32'(data_master),    32'(e.data));
    if (check_starved) check($sformatf("stv@%0d", step), 32'(starved), 32'(e.stv));
  endtask

  initial begin
    HRESETn       = 1'b0;
    slv_HREADY    = 1'b1;
    mst_req       = '0;
    mst_priority  = '0;
    mst_HTRANS    = '0;
    mst_HMASTLOCK = '0;
    can_switch    = '0;
`ifdef MSI_ARB_AGING_EN
    check_starved = 1'b0;
`else
    check_starved = 1'b1;
`endif
    #12;
    check_reset("rst");
    HRESETn = 1'b1;

    // Equal priorities, round-robin rotation on burst boundaries.
    mst_req = 5'b00110;
    set_htrans(1, HTRANS_NONSEQ);
    set_htrans(2, HTRANS_NONSEQ);
    cyc(5'b00010, 1'b1, 5'b00000, 5'b0);
    can_switch = 5'b00010;
    cyc(5'b00100, 1'b1, 5'b00010, 5'b0);
    can_switch = 5'b00100;
    cyc(5'b00010, 1'b1, 5'b00100, 5'b0);
    can_switch = 5'b00000;
    cyc(5'b00010, 1'b1, 5'b00010, 5'b0);

    // Priority wins; release hands over to the remaining requester; park.
    mst_HTRANS = '0;
    set_prio(0, 1);
    set_prio(3, 5);
    mst_req = 5'b01001;
    set_htrans(0, HTRANS_NONSEQ);
    set_htrans(3, HTRANS_NONSEQ);
    cyc(5'b01000, 1'b1, 5'b00010, 5'b0);
    mst_req = 5'b00001;
    set_htrans(3, HTRANS_IDLE);
    cyc(5'b00001, 1'b1, 5'b01000, 5'b0);
    mst_req    = '0;
    mst_HTRANS = '0;
    cyc(5'b00001, 1'b0, 5'b00001, 5'b0);
    cyc(5'b00001, 1'b0, 5'b00000, 5'b0);

    // Locked sequence holds against a higher-priority requester.
    mst_priority = '0;
    set_prio(2, 1);
    set_prio(4, 6);
    mst_req = 5'b00100;
    set_htrans(2, HTRANS_NONSEQ);
    mst_HMASTLOCK = 5'b00100;
    cyc(5'b00100, 1'b1, 5'b00000, 5'b0);
    mst_req = 5'b10100;
    set_htrans(4, HTRANS_NONSEQ);
    can_switch = '1;
    cyc(5'b00100, 1'b1, 5'b00100, 5'b0);
    set_htrans(2, HTRANS_SEQ);
    for (int k = 0; k < 9; k++) cyc(5'b00100, 1'b1, 5'b00100, 5'b0);
    mst_HMASTLOCK = '0;
    set_htrans(2, HTRANS_IDLE);
    mst_req = 5'b10000;
    cyc(5'b00100, 1'b1, 5'b00100, 5'b0);
    cyc(5'b10000, 1'b1, 5'b00100, 5'b0);

    // HREADY low freezes everything while the owner releases.
    can_switch = '0;
    cyc(5'b10000, 1'b1, 5'b10000, 5'b0);
    slv_HREADY = 1'b0;
    mst_req    = 5'b00001;
    set_htrans(4, HTRANS_IDLE);
    set_htrans(0, HTRANS_NONSEQ);
    for (int k = 0; k < 5; k++) cyc(5'b10000, 1'b1, 5'b10000, 5'b0);
    slv_HREADY = 1'b1;
    cyc(5'b00001, 1'b1, 5'b10000, 5'b0);

    // Reset asserted while locked with data_master on master 2.
    mst_req    = 5'b00100;
    mst_HTRANS = '0;
    set_htrans(2, HTRANS_NONSEQ);
    mst_HMASTLOCK = 5'b00100;
    cyc(5'b00100, 1'b1, 5'b00001, 5'b0);
    cyc(5'b00100, 1'b1, 5'b00100, 5'b0);
    #2 HRESETn = 1'b0;
    #1 check_reset("rst_lock");
    mst_req       = '0;
    mst_HMASTLOCK = '0;
    mst_HTRANS    = '0;
    mst_priority  = '0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    // last is back at 4, so masters 2 and 3 tie and 2 wins.
    mst_req = 5'b01100;
    set_htrans(2, HTRANS_NONSEQ);
    set_htrans(3, HTRANS_NONSEQ);
    cyc(5'b00100, 1'b1, 5'b00000, 5'b0);

`ifdef MSI_ARB_AGING_EN
    // Low-priority master ages past a continuously switching high-priority one.
    HRESETn = 1'b0;
    #2 HRESETn = 1'b1;
    check_starved = 1'b1;
    mst_priority  = '0;
    set_prio(0, 7);
    mst_HTRANS = '0;
    set_htrans(0, HTRANS_NONSEQ);
    set_htrans(1, HTRANS_NONSEQ);
    mst_req    = 5'b00011;
    can_switch = 5'b00001;
    cyc(5'b00001, 1'b1, 5'b00000, 5'b00000);
    cyc(5'b00001, 1'b1, 5'b00001, 5'b00000);
    cyc(5'b00001, 1'b1, 5'b00001, 5'b00000);
    cyc(5'b00001, 1'b1, 5'b00001, 5'b00010);
    cyc(5'b00010, 1'b1, 5'b00001, 5'b00000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
